// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end.
//   CLK_HZ                    system clock frequency
//   BTN_*                     button channel indices
//   *_DEFAULT                 default timing constants derived from CLK_HZ
//   rpt_state_e               per-channel auto-repeat state
//   max_int                   helper for sizing shared counters
package stopwatch_pkg;

    localparam int CLK_HZ = 100_000_000;

    localparam int BTN_SET   = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    localparam int NUM_BUTTONS_DEFAULT          = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT      = CLK_HZ / 100;  // 10 ms
    localparam int REPEAT_DELAY_CYCLES_DEFAULT  = CLK_HZ / 2;    // 500 ms
    localparam int REPEAT_PERIOD_CYCLES_DEFAULT = CLK_HZ / 10;   // 10 Hz
    localparam logic [31:0] REPEAT_MASK_DEFAULT =
        (32'd1 << BTN_UP) | (32'd1 << BTN_DOWN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchroniser, debouncer and auto-repeat FSM.
//   clk          system clock
//   rst          asynchronous, active-high reset
//   btn_raw      raw pad input (asynchronous, bouncy)
//   btn_level    debounced level (registered)
//   btn_press    1-cycle pulse on accepted press and on each auto-repeat
//   btn_release  1-cycle pulse on accepted release
//
// Repeat FSM states:
//   state  | meaning
//   IDLE   | not held, or auto-repeat disabled for this channel
//   DELAY  | held; counting down to the first auto-repeat pulse
//   REPEAT | held; emitting a pulse every REPEAT_PERIOD_CYCLES
module button_channel
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT,
    parameter bit REPEAT_EN            = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;

    localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_TC = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic [DW-1:0] cnt;

    rpt_state_e    state;
    logic [RW-1:0] rcnt;

    logic press_evt;
    logic release_evt;
    logic repeat_fire;

    // The debounced value lands in 'stable'; btn_level is one more register
    // behind it so the press/release pulses line up with the level edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            if (sync_2 != stable) begin
                if (cnt == DB_TC) begin
                    stable <= sync_2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press_evt   = stable & ~btn_level;
    assign release_evt = ~stable & btn_level;

    // A release in the same cycle as a terminal count suppresses the pulse.
    always_comb begin
        repeat_fire = 1'b0;
        case (state)
            DELAY:   repeat_fire = !release_evt && (rcnt == DELAY_TC);
            REPEAT:  repeat_fire = !release_evt && (rcnt == PERIOD_TC);
            default: repeat_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= stable;
            btn_press   <= press_evt | repeat_fire;
            btn_release <= release_evt;
            case (state)
                IDLE: begin
                    rcnt <= '0;
                    if (REPEAT_EN && press_evt) begin
                        state <= DELAY;
                    end
                end
                DELAY: begin
                    if (release_evt) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (repeat_fire) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                REPEAT: begin
                    if (release_evt) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (repeat_fire) begin
                        rcnt <= '0;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch push-button front end: NUM_BUTTONS independent conditioned channels.
//   clk          system clock (100 MHz)
//   rst          asynchronous, active-high reset
//   btn_raw      raw pad inputs, one bit per button
//   btn_level    debounced levels
//   btn_press    1-cycle press pulses (plus auto-repeat on REPEAT_MASK channels)
//   btn_release  1-cycle release pulses
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int          NUM_BUTTONS          = NUM_BUTTONS_DEFAULT,
    parameter int          DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
    parameter int          REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEFAULT,
    parameter int          REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEFAULT,
    parameter logic [31:0] REPEAT_MASK          = REPEAT_MASK_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    if (NUM_BUTTONS < 1) begin : g_bad_num
        $error("button_conditioner: NUM_BUTTONS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_rd
        $error("button_conditioner: REPEAT_DELAY_CYCLES must be >= 1");
    end
    if (REPEAT_PERIOD_CYCLES < 1) begin : g_bad_rp
        $error("button_conditioner: REPEAT_PERIOD_CYCLES must be >= 1");
    end
    // Any mask bit above the last channel names a button that does not exist.
    if ((REPEAT_MASK >> NUM_BUTTONS) != 32'd0) begin : g_bad_mask
        $error("button_conditioner: REPEAT_MASK wider than NUM_BUTTONS");
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .REPEAT_EN            (REPEAT_MASK[i])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    import stopwatch_pkg::*;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam logic [NB-1:0] MASK = 5'b00110;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    button_conditioner #(
        .NUM_BUTTONS          (NB),
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .REPEAT_MASK          (32'(MASK))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level is accepted when the last DB synchronised samples all disagree with
    // the current accepted value; synchronised sample at edge n is raw from n-2.
    // Auto-repeat is a function of how long the level has been held.
    logic [NB-1:0] m_acc   = '0;
    logic [NB-1:0] m_lvl   = '0;
    logic [NB-1:0] m_press = '0;
    logic [NB-1:0] m_rel   = '0;
    logic [15:0]   m_hist [NB];
    int            m_held [NB];

    initial begin
        for (int c = 0; c < NB; c++) begin
            m_hist[c] = '0;
            m_held[c] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] h;
        logic        a_prev;
        logic        l_prev;
        logic        flip;
        int          t;
        logic        rep;
        if (rst) begin
            m_acc   <= '0;
            m_lvl   <= '0;
            m_press <= '0;
            m_rel   <= '0;
            for (int c = 0; c < NB; c++) begin
                m_hist[c] <= '0;
                m_held[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NB; c++) begin
                a_prev = m_acc[c];
                l_prev = m_lvl[c];
                h = {m_hist[c][14:0], btn_raw[c]};
                flip = 1'b1;
                for (int k = 2; k <= DB + 1; k++) begin
                    if (h[k] == a_prev) flip = 1'b0;
                end
                if (a_prev && !l_prev) t = 0;
                else if (a_prev)       t = m_held[c] + 1;
                else                   t = 0;
                rep = MASK[c] && a_prev && l_prev &&
                      ((t == RD) || (t > RD && ((t - RD) % RP) == 0));
                m_hist[c]  <= h;
                m_held[c]  <= t;
                m_acc[c]   <= flip ? ~a_prev : a_prev;
                m_lvl[c]   <= a_prev;
                m_rel[c]   <= ~a_prev & l_prev;
                m_press[c] <= (a_prev & ~l_prev) | rep;
            end
        end
    end

    // ---------------- event log + per-cycle compare ----------------
    typedef struct {
        int cyc;
        int ch;
        bit rel;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk) begin
        ev_t e;
        for (int c = 0; c < NB; c++) begin
            if (btn_press[c] === 1'b1) begin
                e.cyc = cyc; e.ch = c; e.rel = 1'b0;
                evq.push_back(e);
            end
            if (btn_release[c] === 1'b1) begin
                e.cyc = cyc; e.ch = c; e.rel = 1'b1;
                evq.push_back(e);
            end
        end
        chk("model_level",   int'(btn_level),   int'(m_lvl));
        chk("model_press",   int'(btn_press),   int'(m_press));
        chk("model_release", int'(btn_release), int'(m_rel));
    end

    function automatic int n_ev(input int ch, input bit rel, input int lo, input int hi);
        int n = 0;
        foreach (evq[i])
            if (evq[i].ch == ch && evq[i].rel == rel && evq[i].cyc >= lo && evq[i].cyc <= hi) n++;
        return n;
    endfunction

    function automatic int first_ev(input int ch, input bit rel, input int lo);
        int f = -1;
        foreach (evq[i])
            if (evq[i].ch == ch && evq[i].rel == rel && evq[i].cyc >= lo && (f < 0 || evq[i].cyc < f))
                f = evq[i].cyc;
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed stimulus ----------------
    int s, tp, s2, tp2, r;
    int offs [9] = '{0, 20, 25, 30, 35, 40, 45, 50, 55};

    initial begin
        // 1. reset with all buttons held, then fresh presses
        btn_raw = 5'b11111;
        rst = 1'b1;
        step(3);
        chk("t1_rst_level",   int'(btn_level),   0);
        chk("t1_rst_press",   int'(btn_press),   0);
        chk("t1_rst_release", int'(btn_release), 0);
        rst = 1'b0;
        s = cyc;
        step(14);
        for (int c = 0; c < NB; c++) begin
            chk("t1_press_cycle", first_ev(c, 1'b0, s), s + 7);
            chk("t1_press_count", n_ev(c, 1'b0, s, cyc), 1);
        end
        btn_raw = '0;
        step(12);
        for (int c = 0; c < NB; c++)
            chk("t1_release_cycle", first_ev(c, 1'b1, s), s + 21);

        // 2. short bounces on channel 3 are rejected
        s = cyc;
        repeat (5) begin
            btn_raw[BTN_LEFT] = 1'b1;
            step(3);
            btn_raw[BTN_LEFT] = 1'b0;
            step(3);
        end
        step(10);
        chk("t2_bounce_press",   n_ev(BTN_LEFT, 1'b0, s, cyc), 0);
        chk("t2_bounce_release", n_ev(BTN_LEFT, 1'b1, s, cyc), 0);

        // 3. long hold on channel 1: press + auto-repeat, then release
        s = cyc;
        tp = s + 7;
        btn_raw[BTN_UP] = 1'b1;
        step(58);
        btn_raw[BTN_UP] = 1'b0;
        step(30);
        foreach (offs[i])
            chk("t3_repeat_at", n_ev(BTN_UP, 1'b0, tp + offs[i], tp + offs[i]), 1);
        chk("t3_press_total", n_ev(BTN_UP, 1'b0, s, cyc), 9);
        chk("t3_release_cycle", first_ev(BTN_UP, 1'b1, s), tp + 58);

        // 4. long hold on a non-repeat channel: one press only
        s = cyc;
        btn_raw[BTN_LEFT] = 1'b1;
        step(60);
        btn_raw[BTN_LEFT] = 1'b0;
        step(12);
        chk("t4_press_total",   n_ev(BTN_LEFT, 1'b0, s, cyc), 1);
        chk("t4_release_total", n_ev(BTN_LEFT, 1'b1, s, cyc), 1);

        // 5. release lands on a repeat terminal count
        s = cyc;
        tp = s + 7;
        btn_raw[BTN_UP] = 1'b1;
        step(60);
        btn_raw[BTN_UP] = 1'b0;
        step(10);
        chk("t5_release_cycle",    first_ev(BTN_UP, 1'b1, s), tp + 60);
        chk("t5_no_press_at_rel",  n_ev(BTN_UP, 1'b0, tp + 60, tp + 60), 0);
        chk("t5_press_total",      n_ev(BTN_UP, 1'b0, s, cyc), 9);
        s2 = cyc;
        tp2 = s2 + 7;
        btn_raw[BTN_UP] = 1'b1;
        step(30);
        btn_raw[BTN_UP] = 1'b0;
        step(12);
        chk("t5_idle_first_rep", n_ev(BTN_UP, 1'b0, tp2 + 20, tp2 + 20), 1);
        chk("t5_idle_press_tot", n_ev(BTN_UP, 1'b0, s2, cyc), 3);

        // 6. simultaneous presses, reset mid-repeat
        s = cyc;
        tp = s + 7;
        btn_raw = 5'b00110;
        step(35);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        r = cyc;
        step(35);
        btn_raw = '0;
        step(12);
        for (int c = BTN_UP; c <= BTN_DOWN; c++) begin
            chk("t6_pre_press0",  n_ev(c, 1'b0, tp, tp), 1);
            chk("t6_pre_rep1",    n_ev(c, 1'b0, tp + 20, tp + 20), 1);
            chk("t6_pre_rep2",    n_ev(c, 1'b0, tp + 25, tp + 25), 1);
            chk("t6_pre_total",   n_ev(c, 1'b0, s, r), 3);
            chk("t6_no_rel_rst",  n_ev(c, 1'b1, s, r), 0);
            chk("t6_post_press",  first_ev(c, 1'b0, r), r + 7);
            chk("t6_post_rep1",   n_ev(c, 1'b0, r + 27, r + 27), 1);
            chk("t6_post_total",  n_ev(c, 1'b0, r, cyc), 4);
            chk("t6_post_rel",    n_ev(c, 1'b1, r, cyc), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
